// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: registers the ioctl byte stream, decodes eprom regions,
// counts bytes and holds the core in reset until a full image has settled.
module rom_dl_ctrl #(
    parameter logic [24:0] ROM_END     = 25'h58000,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IOCTL_DOWNLOAD,
    input  logic [7:0]  IOCTL_INDEX,
    input  logic        IOCTL_WR,
    input  logic [24:0] IOCTL_ADDR,
    input  logic [7:0]  IOCTL_DOUT,
    output logic [24:0] DL_ADDR,
    output logic [7:0]  DL_DATA,
    output logic        DL_WR,
    output logic [14:0] REGION_SEL,
    output logic        CORE_RESET,
    output logic        ROM_OK,
    output logic        ROM_ERR,
    output logic [24:0] BYTE_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic        dl_d;
    logic        start;
    logic        accept;
    logic [7:0]  hold_cnt;
    logic [14:0] region_dec;

    // dl_d resets high so a download already in flight at reset is never seen as a start.
    assign start  = IOCTL_DOWNLOAD && !dl_d && (IOCTL_INDEX == 8'd0);
    assign accept = (state == S_LOAD) && IOCTL_DOWNLOAD && IOCTL_WR;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (!IOCTL_DOWNLOAD) state_nxt = S_CHECK;
            S_CHECK: state_nxt = (BYTE_COUNT >= ROM_END) ? S_HOLD : S_ERROR;
            S_HOLD: begin
                if (start)                 state_nxt = S_LOAD;
                else if (hold_cnt == 8'd0) state_nxt = S_RUN;
            end
            S_RUN, S_ERROR: if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CORE_RESET = 1'b1;
        ROM_OK     = 1'b0;
        ROM_ERR    = 1'b0;
        if (state == S_RUN) begin
            CORE_RESET = 1'b0;
            ROM_OK     = 1'b1;
        end
        if (state == S_ERROR) ROM_ERR = 1'b1;
    end

    // Priority by ascending address; 'h16000-'h17FFF is a dummy hole mapped to bit 14.
    always_comb begin
        region_dec = '0;
        if      (IOCTL_ADDR < 25'h08000) region_dec[0]  = 1'b1;
        else if (IOCTL_ADDR < 25'h10000) region_dec[1]  = 1'b1;
        else if (IOCTL_ADDR < 25'h12000) region_dec[2]  = 1'b1;
        else if (IOCTL_ADDR < 25'h14000) region_dec[3]  = 1'b1;
        else if (IOCTL_ADDR < 25'h16000) region_dec[4]  = 1'b1;
        else if (IOCTL_ADDR < 25'h18000) region_dec[14] = 1'b1;
        else if (IOCTL_ADDR < 25'h20000) region_dec[5]  = 1'b1;
        else if (IOCTL_ADDR < 25'h28000) region_dec[6]  = 1'b1;
        else if (IOCTL_ADDR < 25'h30000) region_dec[7]  = 1'b1;
        else if (IOCTL_ADDR < 25'h38000) region_dec[8]  = 1'b1;
        else if (IOCTL_ADDR < 25'h40000) region_dec[9]  = 1'b1;
        else if (IOCTL_ADDR < 25'h48000) region_dec[10] = 1'b1;
        else if (IOCTL_ADDR < 25'h50000) region_dec[11] = 1'b1;
        else if (IOCTL_ADDR < 25'h58000) region_dec[12] = 1'b1;
        else                             region_dec[13] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            dl_d       <= 1'b1;
            hold_cnt   <= '0;
            DL_WR      <= 1'b0;
            DL_ADDR    <= '0;
            DL_DATA    <= '0;
            REGION_SEL <= '0;
            BYTE_COUNT <= '0;
        end else begin
            state <= state_nxt;
            dl_d  <= IOCTL_DOWNLOAD;
            DL_WR <= accept;
            if (accept) begin
                DL_ADDR    <= IOCTL_ADDR;
                DL_DATA    <= IOCTL_DOUT;
                REGION_SEL <= region_dec;
            end

            if (state_nxt == S_LOAD && state != S_LOAD)
                BYTE_COUNT <= '0;
            else if (accept && BYTE_COUNT != '1)
                BYTE_COUNT <= BYTE_COUNT + 25'd1;

            if (state_nxt == S_HOLD && state != S_HOLD)
                hold_cnt <= HOLD_INIT;
            else if (state == S_HOLD && hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

endmodule
